// File: rtl/msi_cache_controller_if.sv
// Signal bundle between the MSI controller and its CPU, block, bus and memory.
// Optional MSI_CACHE_STATS_EN adds the hit/miss counters.
interface msi_cache_controller_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4
);
    // valid/ready: a transfer happens on the rising clock edge where both are high;
    // valid holds its payload until then, ready never depends on a later valid.
    logic                  cpu_req_valid;
    logic                  cpu_req_ready;
    logic                  cpu_req_write;
    logic [ADDR_WIDTH-1:0] cpu_req_address;
    logic [DATA_WIDTH-1:0] cpu_req_data;
    logic                  cpu_resp_valid;
    logic [DATA_WIDTH-1:0] cpu_resp_data;
    logic                  cpu_resp_hit;

    logic [1:0]            current_state;
    logic [ADDR_WIDTH-1:0] current_address;
    logic [DATA_WIDTH-1:0] current_data;
    logic                  write;
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;

    logic                  snoop_valid;
    logic                  snoop_ready;
    logic [1:0]            snoop_op;
    logic [ADDR_WIDTH-1:0] snoop_address;
    logic                  bus_valid;
    logic [1:0]            bus_op;
    logic [ADDR_WIDTH-1:0] bus_address;

    logic                  mem_wb_valid;
    logic                  mem_rd_valid;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;
`ifdef MSI_CACHE_STATS_EN
    logic [7:0]            hit_count;
    logic [7:0]            miss_count;
`endif

    modport master (
        input  cpu_req_valid, cpu_req_write, cpu_req_address, cpu_req_data,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
        input  current_state, current_address, current_data,
        output write, state, address, data_in,
        input  snoop_valid, snoop_op, snoop_address,
        output snoop_ready, bus_valid, bus_op, bus_address,
        input  mem_rdata, mem_ack,
        output mem_wb_valid, mem_rd_valid, mem_address, mem_wdata
`ifdef MSI_CACHE_STATS_EN
        , output hit_count, output miss_count
`endif
    );

    modport slave (
        output cpu_req_valid, cpu_req_write, cpu_req_address, cpu_req_data,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
        output current_state, current_address, current_data,
        input  write, state, address, data_in,
        output snoop_valid, snoop_op, snoop_address,
        input  snoop_ready, bus_valid, bus_op, bus_address,
        output mem_rdata, mem_ack,
        input  mem_wb_valid, mem_rd_valid, mem_address, mem_wdata
`ifdef MSI_CACHE_STATS_EN
        , input hit_count, input miss_count
`endif
    );
endinterface

// File: rtl/msi_cache_controller.sv
// MSI coherence controller for one single-line block: CPU requests, snoops,
// writebacks and fetches. Define MSI_CACHE_STATS_EN for hit/miss counters.
module msi_cache_controller #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    msi_cache_controller_if.master bus,
    output logic [2:0]             o_dbg_fsm
);
    typedef enum logic [2:0] {
        S_IDLE, S_WB, S_FETCH, S_SNP_WB, S_UPDATE, S_RESP
    } fsm_t;

    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10;
    localparam logic [1:0] OP_RM = 2'b00, OP_WM = 2'b01, OP_INV = 2'b10;

    fsm_t                  r_fsm;
    logic                  r_rdy;
    logic                  r_wr;
    logic                  r_hit;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_snp_state;

    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_hit;
    logic                  r_write;
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic                  r_bus_valid;
    logic [1:0]            r_bus_op;
    logic [ADDR_WIDTH-1:0] r_bus_address;
    logic                  r_mem_wb_valid;
    logic                  r_mem_rd_valid;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic w_cpu_fire;
    logic w_snp_fire;
    logic w_hit;
    logic w_snp_match;

    // r_rdy is high only in IDLE; the snoop gate lets a snoop win the same cycle.
    assign w_snp_fire  = bus.snoop_valid & r_rdy;
    assign w_cpu_fire  = bus.cpu_req_valid & r_rdy & ~bus.snoop_valid;
    assign w_hit       = (bus.current_state != ST_I) && (bus.current_address == bus.cpu_req_address);
    assign w_snp_match = (bus.current_state != ST_I) && (bus.snoop_address == bus.current_address);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm          <= S_IDLE;
            r_rdy          <= 1'b0;
            r_wr           <= 1'b0;
            r_hit          <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rdata        <= '0;
            r_snp_state    <= ST_I;
            r_resp_valid   <= 1'b0;
            r_resp_data    <= '0;
            r_resp_hit     <= 1'b0;
            r_write        <= 1'b0;
            r_state        <= ST_I;
            r_address      <= '0;
            r_data_in      <= '0;
            r_bus_valid    <= 1'b0;
            r_bus_op       <= OP_RM;
            r_bus_address  <= '0;
            r_mem_wb_valid <= 1'b0;
            r_mem_rd_valid <= 1'b0;
            r_mem_address  <= '0;
            r_mem_wdata    <= '0;
        end else begin
            r_write      <= 1'b0;
            r_bus_valid  <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    r_rdy <= 1'b1;
                    if (w_snp_fire) begin
                        if (w_snp_match && bus.current_state == ST_M) begin
                            if (bus.snoop_op == OP_INV) begin
                                r_write   <= 1'b1;
                                r_state   <= ST_I;
                                r_address <= bus.current_address;
                                r_data_in <= bus.current_data;
                                r_rdy     <= 1'b0;
                            end else if (bus.snoop_op == OP_RM || bus.snoop_op == OP_WM) begin
                                r_snp_state    <= (bus.snoop_op == OP_RM) ? ST_S : ST_I;
                                r_mem_wb_valid <= 1'b1;
                                r_mem_address  <= bus.current_address;
                                r_mem_wdata    <= bus.current_data;
                                r_rdy          <= 1'b0;
                                r_fsm          <= S_SNP_WB;
                            end
                        end else if (w_snp_match && bus.snoop_op != OP_RM) begin
                            r_write   <= 1'b1;
                            r_state   <= ST_I;
                            r_address <= bus.current_address;
                            r_data_in <= bus.current_data;
                            r_rdy     <= 1'b0;
                        end
                    end else if (w_cpu_fire) begin
                        r_rdy   <= 1'b0;
                        r_wr    <= bus.cpu_req_write;
                        r_addr  <= bus.cpu_req_address;
                        r_wdata <= bus.cpu_req_data;
                        r_hit   <= w_hit;
                        if (w_hit && !bus.cpu_req_write) begin
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= bus.current_data;
                            r_resp_hit   <= 1'b1;
                            r_fsm        <= S_RESP;
                        end else if (w_hit) begin
                            r_write   <= 1'b1;
                            r_state   <= ST_M;
                            r_address <= bus.cpu_req_address;
                            r_data_in <= bus.cpu_req_data;
                            if (bus.current_state == ST_S) begin
                                r_bus_valid   <= 1'b1;
                                r_bus_op      <= OP_INV;
                                r_bus_address <= bus.cpu_req_address;
                            end
                            r_fsm <= S_RESP;
                        end else if (bus.current_state == ST_M) begin
                            r_mem_wb_valid <= 1'b1;
                            r_mem_address  <= bus.current_address;
                            r_mem_wdata    <= bus.current_data;
                            r_fsm          <= S_WB;
                        end else begin
                            r_bus_valid    <= 1'b1;
                            r_bus_op       <= bus.cpu_req_write ? OP_WM : OP_RM;
                            r_bus_address  <= bus.cpu_req_address;
                            r_mem_rd_valid <= 1'b1;
                            r_mem_address  <= bus.cpu_req_address;
                            r_fsm          <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (bus.mem_ack) begin
                        r_mem_wb_valid <= 1'b0;
                        r_bus_valid    <= 1'b1;
                        r_bus_op       <= r_wr ? OP_WM : OP_RM;
                        r_bus_address  <= r_addr;
                        r_mem_rd_valid <= 1'b1;
                        r_mem_address  <= r_addr;
                        r_fsm          <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        r_mem_rd_valid <= 1'b0;
                        r_rdata        <= bus.mem_rdata;
                        r_fsm          <= S_UPDATE;
                    end
                end
                S_SNP_WB: begin
                    // Back to IDLE with r_rdy low so the next decision sees the updated block.
                    if (bus.mem_ack) begin
                        r_mem_wb_valid <= 1'b0;
                        r_write        <= 1'b1;
                        r_state        <= r_snp_state;
                        r_address      <= bus.current_address;
                        r_data_in      <= bus.current_data;
                        r_fsm          <= S_IDLE;
                    end
                end
                S_UPDATE: begin
                    r_write   <= 1'b1;
                    r_state   <= r_wr ? ST_M : ST_S;
                    r_address <= r_addr;
                    r_data_in <= r_wr ? r_wdata : r_rdata;
                    r_fsm     <= S_RESP;
                end
                S_RESP: begin
                    // Entered with the pulse already issued (read hit) or still owed (after a write).
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= r_wr ? '0 : r_rdata;
                        r_resp_hit   <= r_hit;
                    end else begin
                        r_rdy <= 1'b1;
                        r_fsm <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

`ifdef MSI_CACHE_STATS_EN
    logic [7:0] r_hit_count;
    logic [7:0] r_miss_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_cpu_fire && r_fsm == S_IDLE) begin
            if (w_hit && r_hit_count != 8'hFF)
                r_hit_count <= r_hit_count + 8'd1;
            else if (!w_hit && r_miss_count != 8'hFF)
                r_miss_count <= r_miss_count + 8'd1;
        end
    end

    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;
`endif

    assign bus.cpu_req_ready  = r_rdy & ~bus.snoop_valid;
    assign bus.snoop_ready    = r_rdy;
    assign bus.cpu_resp_valid = r_resp_valid;
    assign bus.cpu_resp_data  = r_resp_data;
    assign bus.cpu_resp_hit   = r_resp_hit;
    assign bus.write          = r_write;
    assign bus.state          = r_state;
    assign bus.address        = r_address;
    assign bus.data_in        = r_data_in;
    assign bus.bus_valid      = r_bus_valid;
    assign bus.bus_op         = r_bus_op;
    assign bus.bus_address    = r_bus_address;
    assign bus.mem_wb_valid   = r_mem_wb_valid;
    assign bus.mem_rd_valid   = r_mem_rd_valid;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_wdata      = r_mem_wdata;
    assign o_dbg_fsm          = r_fsm;
endmodule

// File: tb/tb_msi_cache_controller.sv
// Directed bench for msi_cache_controller: the block itself is modelled here,
// every expected value is hand-derived in the step sequence below.
module tb_msi_cache_controller;
    localparam int AW = 3;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    dbg_fsm;
    int            checks = 0;
    int            errors = 0;
    int            wr_pulses = 0;
    int            n_wr;
    logic          pre_load = 1'b0;
    logic [1:0]    pre_state = 2'b00;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    msi_cache_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    msi_cache_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .o_dbg_fsm (dbg_fsm)
    );

    always #5 clock = ~clock;

    // Block storage: no reset, updated on the edge that ends a write pulse.
    always @(posedge clock) begin
        if (pre_load) begin
            bus.current_state   <= pre_state;
            bus.current_address <= pre_addr;
            bus.current_data    <= pre_data;
        end else if (bus.write) begin
            bus.current_state   <= bus.state;
            bus.current_address <= bus.address;
            bus.current_data    <= bus.data_in;
        end
    end

    always @(posedge clock) if (bus.write) wr_pulses <= wr_pulses + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [1:0] st, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_state = st;
        pre_addr  = a;
        pre_data  = d;
        pre_load  = 1'b1;
        tick();
        pre_load  = 1'b0;
    endtask

    task automatic cpu_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bus.cpu_req_valid   = 1'b1;
        bus.cpu_req_write   = wr;
        bus.cpu_req_address = a;
        bus.cpu_req_data    = d;
        while (!bus.cpu_req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_before_accept", bus.cpu_req_ready, 1);
        tick();
        bus.cpu_req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_req_valid = 0; bus.cpu_req_write = 0; bus.cpu_req_address = '0; bus.cpu_req_data = '0;
        bus.snoop_valid = 0; bus.snoop_op = 2'b00; bus.snoop_address = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;

        // Reset
        preload(2'b00, 3'd0, 4'h0);
        tick();
        check("rst_cpu_req_ready", bus.cpu_req_ready, 0);
        check("rst_snoop_ready", bus.snoop_ready, 0);
        check("rst_write", bus.write, 0);
        check("rst_mem_rd_valid", bus.mem_rd_valid, 0);
        check("rst_mem_wb_valid", bus.mem_wb_valid, 0);
        check("rst_resp_valid", bus.cpu_resp_valid, 0);
        check("rst_bus_valid", bus.bus_valid, 0);
        check("rst_fsm", dbg_fsm, 0);
        reset_n = 1'b1;
        tick();
        check("post_rst_cpu_ready", bus.cpu_req_ready, 1);
        check("post_rst_snoop_ready", bus.snoop_ready, 1);

        // Read miss from I
        cpu_req(1'b0, 3'd3, 4'h0);
        check("t1_bus_valid", bus.bus_valid, 1);
        check("t1_bus_op", bus.bus_op, 2'b00);
        check("t1_bus_addr", bus.bus_address, 3);
        check("t1_rd_valid", bus.mem_rd_valid, 1);
        check("t1_mem_addr", bus.mem_address, 3);
        tick();
        check("t1_bus_pulse_end", bus.bus_valid, 0);
        check("t1_rd_held", bus.mem_rd_valid, 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 4'hA;
        tick();
        bus.mem_ack = 1'b0;
        check("t1_rd_dropped", bus.mem_rd_valid, 0);
        tick();
        check("t1_write", bus.write, 1);
        check("t1_state", bus.state, 2'b01);
        check("t1_data_in", bus.data_in, 4'hA);
        check("t1_address", bus.address, 3);
        tick();
        check("t1_resp_valid", bus.cpu_resp_valid, 1);
        check("t1_resp_data", bus.cpu_resp_data, 4'hA);
        check("t1_resp_hit", bus.cpu_resp_hit, 0);
        check("t1_block_state", bus.current_state, 2'b01);
        tick();
        check("t1_resp_end", bus.cpu_resp_valid, 0);
        check("t1_ready_again", bus.cpu_req_ready, 1);

        // Write hit on S
        preload(2'b01, 3'd3, 4'hA);
        cpu_req(1'b1, 3'd3, 4'h5);
        check("t2_write", bus.write, 1);
        check("t2_state", bus.state, 2'b10);
        check("t2_data_in", bus.data_in, 4'h5);
        check("t2_bus_valid", bus.bus_valid, 1);
        check("t2_bus_op", bus.bus_op, 2'b10);
        check("t2_bus_addr", bus.bus_address, 3);
        check("t2_no_resp_yet", bus.cpu_resp_valid, 0);
        tick();
        check("t2_resp_valid", bus.cpu_resp_valid, 1);
        check("t2_resp_hit", bus.cpu_resp_hit, 1);
        check("t2_write_pulse_end", bus.write, 0);
        tick();

        // Read hit on M (block now M addr 3 data 5)
        n_wr = wr_pulses;
        cpu_req(1'b0, 3'd3, 4'h0);
        check("t2b_resp_valid", bus.cpu_resp_valid, 1);
        check("t2b_resp_data", bus.cpu_resp_data, 4'h5);
        check("t2b_resp_hit", bus.cpu_resp_hit, 1);
        check("t2b_no_write", bus.write, 0);
        tick();
        check("t2b_no_write_count", wr_pulses, n_wr);

        // Read miss with dirty victim
        preload(2'b10, 3'd2, 4'h7);
        cpu_req(1'b0, 3'd5, 4'h0);
        check("t3_wb_valid", bus.mem_wb_valid, 1);
        check("t3_wb_addr", bus.mem_address, 2);
        check("t3_wb_data", bus.mem_wdata, 4'h7);
        check("t3_no_fetch_yet", bus.mem_rd_valid, 0);
        tick(); tick();
        check("t3_wb_held", bus.mem_wb_valid, 1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("t3_wb_done", bus.mem_wb_valid, 0);
        check("t3_rd_valid", bus.mem_rd_valid, 1);
        check("t3_rd_addr", bus.mem_address, 5);
        check("t3_bus_valid", bus.bus_valid, 1);
        check("t3_bus_op", bus.bus_op, 2'b00);
        check("t3_bus_addr", bus.bus_address, 5);
        bus.mem_ack = 1'b1; bus.mem_rdata = 4'h9;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        check("t3_write", bus.write, 1);
        check("t3_state", bus.state, 2'b01);
        check("t3_address", bus.address, 5);
        check("t3_data_in", bus.data_in, 4'h9);
        tick();
        check("t3_resp_data", bus.cpu_resp_data, 4'h9);
        check("t3_resp_hit", bus.cpu_resp_hit, 0);
        check("t3_block_state", bus.current_state, 2'b01);
        check("t3_block_addr", bus.current_address, 5);
        tick();

        // Snoop READ_MISS on M racing a CPU request
        preload(2'b10, 3'd2, 4'h7);
        bus.snoop_valid = 1'b1; bus.snoop_op = 2'b00; bus.snoop_address = 3'd2;
        bus.cpu_req_valid = 1'b1; bus.cpu_req_write = 1'b0; bus.cpu_req_address = 3'd2;
        #1;
        check("t4_cpu_blocked", bus.cpu_req_ready, 0);
        check("t4_snoop_ready", bus.snoop_ready, 1);
        tick();
        bus.snoop_valid = 1'b0;
        check("t4_wb_valid", bus.mem_wb_valid, 1);
        check("t4_wb_addr", bus.mem_address, 2);
        check("t4_wb_data", bus.mem_wdata, 4'h7);
        check("t4_cpu_wait", bus.cpu_req_ready, 0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("t4_write", bus.write, 1);
        check("t4_state", bus.state, 2'b01);
        check("t4_address", bus.address, 2);
        check("t4_data_in", bus.data_in, 4'h7);
        check("t4_cpu_wait2", bus.cpu_req_ready, 0);
        tick();
        check("t4_cpu_ready", bus.cpu_req_ready, 1);
        check("t4_block_state", bus.current_state, 2'b01);
        tick();
        bus.cpu_req_valid = 1'b0;
        check("t4_resp_valid", bus.cpu_resp_valid, 1);
        check("t4_resp_hit", bus.cpu_resp_hit, 1);
        check("t4_resp_data", bus.cpu_resp_data, 4'h7);
        tick();

        // Snoop WRITE_MISS on S: non-matching then matching
        preload(2'b01, 3'd1, 4'h6);
        n_wr = wr_pulses;
        bus.snoop_valid = 1'b1; bus.snoop_op = 2'b01; bus.snoop_address = 3'd4;
        tick();
        bus.snoop_valid = 1'b0;
        check("t5_nomatch_write", bus.write, 0);
        check("t5_nomatch_ready", bus.snoop_ready, 1);
        tick();
        check("t5_nomatch_count", wr_pulses, n_wr);
        check("t5_nomatch_state", bus.current_state, 2'b01);
        bus.snoop_valid = 1'b1; bus.snoop_address = 3'd1;
        tick();
        bus.snoop_valid = 1'b0;
        check("t5_write", bus.write, 1);
        check("t5_state", bus.state, 2'b00);
        check("t5_address", bus.address, 1);
        check("t5_data_in", bus.data_in, 4'h6);
        check("t5_busy", bus.snoop_ready, 0);
        tick();
        check("t5_block_state", bus.current_state, 2'b00);
        check("t5_ready_again", bus.snoop_ready, 1);

        // Snoop INVALIDATE on M: no writeback
        preload(2'b10, 3'd6, 4'h3);
        bus.snoop_valid = 1'b1; bus.snoop_op = 2'b10; bus.snoop_address = 3'd6;
        tick();
        bus.snoop_valid = 1'b0;
        check("t5b_write", bus.write, 1);
        check("t5b_state", bus.state, 2'b00);
        check("t5b_no_wb", bus.mem_wb_valid, 0);
        tick();

        // Stray mem_ack in IDLE is ignored
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("t6a_stray_ack_write", bus.write, 0);
        check("t6a_stray_ack_rd", bus.mem_rd_valid, 0);
        check("t6a_stray_ack_fsm", dbg_fsm, 0);

        // Reset during FETCH
        preload(2'b00, 3'd0, 4'h0);
        n_wr = wr_pulses;
        cpu_req(1'b0, 3'd4, 4'h0);
        check("t6_rd_valid", bus.mem_rd_valid, 1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_rd_valid", bus.mem_rd_valid, 0);
        check("t6_rst_bus_valid", bus.bus_valid, 0);
        check("t6_rst_write", bus.write, 0);
        check("t6_rst_cpu_ready", bus.cpu_req_ready, 0);
        check("t6_rst_snoop_ready", bus.snoop_ready, 0);
        check("t6_rst_fsm", dbg_fsm, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t6_ready_after", bus.cpu_req_ready, 1);
        check("t6_no_block_write", wr_pulses, n_wr);
        check("t6_rd_still_low", bus.mem_rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
